demux_stream_1_n: RTL and testbench
===================================

# demux_stream_1_n

Registered 1-to-N stream demultiplexer with valid/ready handshake on every port. One input beat is routed to the output channel named by `in_sel` and held in that channel's one-entry output register until the downstream consumer takes it. Out-of-range selects are dropped and counted. It is the streaming, back-pressured, parametrised successor to the team's fixed 1:2 combinational demux, and sits between a single producer and N independent consumers.

## Interface
- `WIDTH`, 8: data width per beat, in bits (≥1).
- `CHANNELS`, 4: number of output channels (2..16).
- `SEL_W`, derived localparam = max(1, $clog2(CHANNELS)): select width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input beat payload.
- `in_sel`  in  SEL_W  destination channel index.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out_data`  out  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `out_valid`  out  CHANNELS  per-channel beat present.
- `out_ready`  in  CHANNELS  per-channel consumer accepts.
- `err_cnt`  out  8  saturating count of dropped out-of-range beats.
- `in_bcast`  in  1  present only with `DEMUX_BCAST_EN` (see Configuration).

## Operation
- Per channel k: a one-entry register (`out_data` slice, `out_valid[k]`).
- Channel k is "free" when `!out_valid[k] || out_ready[k]`.
- Accept = `in_valid && in_ready`.
- `in_ready`: if `in_sel < CHANNELS`, equals free(in_sel); else 1 (drop path never stalls).
- On accept with in-range sel: channel sel loads `in_data`, sets `out_valid[sel]`=1.
- Drain: `out_valid[k] && out_ready[k]` clears `out_valid[k]` unless the same cycle loads channel k; simultaneous drain and load keeps valid=1 with new data, so full throughput of one beat per cycle per stream is sustained.
- While `out_valid[k] && !out_ready[k]`, channel k data and valid are held stable (no overwrite).
- Non-loaded channels keep their last data; their valid changes only by their own drain.
- Out-of-range sel (`in_sel >= CHANNELS`, only possible when CHANNELS is not a power of two): beat consumed, no channel loaded, `err_cnt` increments, saturating at 255.
- `in_valid` low: no state change except drains.
- Beats to different channels are independent; a stalled channel blocks only beats addressed to it (head-of-line at the input).

## Timing
- Reset (synchronous, any cycle, including mid-transfer): next edge sets all `out_valid`=0, all `out_data`=0, `err_cnt`=0; any held beats are discarded. `in_ready` is driven per the rules above from the reset state, i.e. 1 during reset for any sel.
- Latency: beat accepted at edge N appears on `out_valid`/`out_data` after edge N (visible cycle N+1).
- `in_ready` is combinational from `in_sel`, `out_valid`, `out_ready` (and `in_bcast`); no combinational path from `in_valid` to `in_ready`.
- All outputs except `in_ready` are registered.

## Configuration
- `DEMUX_BCAST_EN` defined: port `in_bcast` exists. When `in_bcast`=1, `in_sel` is ignored; `in_ready` = AND of free(k) over all channels; on accept, every channel loads `in_data` and sets valid the same cycle; `err_cnt` unaffected. `in_bcast`=0 behaves as unicast.
- `DEMUX_BCAST_EN` not defined: no `in_bcast` port, no broadcast logic; unicast only.

## Test plan
- Reset: drive `rst`=1 with channels holding data -> after one edge `out_valid`=0, `out_data`=0, `err_cnt`=0.
- Unicast, WIDTH=8, CHANNELS=4: send 0xA5 sel=2, all `out_ready`=1 -> cycle later `out_valid`=4'b0100, slice 2 = 0xA5; next cycle valid clears.
- Back-pressure: `out_ready[1]`=0, send 0x11 then 0x22 to sel=1 -> 0x11 held, `in_ready`=0 for second beat; raise `out_ready[1]` -> 0x11 drains and 0x22 loads the same edge, valid stays 1; beats to sel=0 pass unaffected throughout.
- Streaming: 16 back-to-back beats to sel=3 with `out_ready[3]`=1 -> `in_ready` constantly 1, outputs in order, one per cycle.
- Out-of-range, CHANNELS=3: 300 beats with sel=3 -> no `out_valid` asserted, `in_ready`=1, `err_cnt` saturates at 255.
- With `DEMUX_BCAST_EN`: `in_bcast`=1, data 0x5A, `out_ready[0]`=0 with channel 0 full -> `in_ready`=0; release -> all four channels valid with 0x5A on the same cycle.

Source files
------------

// File: rtl/demux_stream_1_n_if.sv
// demux_stream_1_n_if: stream bus for the 1-to-N demux; in_bcast exists only with DEMUX_BCAST_EN.
interface demux_stream_1_n_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    logic [WIDTH-1:0]          in_data;
    logic [SEL_W-1:0]          in_sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [7:0]                err_cnt;
`ifdef DEMUX_BCAST_EN
    logic                      in_bcast;
    modport master (output in_data, in_sel, in_valid, in_bcast, out_ready,
                    input  in_ready, out_data, out_valid, err_cnt);
    modport slave  (input  in_data, in_sel, in_valid, in_bcast, out_ready,
                    output in_ready, out_data, out_valid, err_cnt);
`else
    modport master (output in_data, in_sel, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, err_cnt);
    modport slave  (input  in_data, in_sel, in_valid, out_ready,
                    output in_ready, out_data, out_valid, err_cnt);
`endif
endinterface

// File: rtl/demux_stream_1_n.sv
// demux_stream_1_n: registered 1-to-N valid/ready demux with saturating drop counter.
// Optional broadcast to all channels when DEMUX_BCAST_EN is defined.
module demux_stream_1_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic              clk,
    input logic              rst,
    demux_stream_1_n_if.slave dmx
);
    localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
    logic [CHANNELS-1:0]       out_valid_q, out_valid_d;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic [CHANNELS-1:0]       free, uni_load, load;
    logic                      in_range, uni_ready, accept, drop;

    assign free      = ~out_valid_q | dmx.out_ready;
    assign in_range  = {1'b0, dmx.in_sel} < NCH;
    assign uni_ready = in_range ? free[dmx.in_sel] : 1'b1;
    assign uni_load  = in_range ? {{(CHANNELS-1){1'b0}}, 1'b1} << dmx.in_sel : '0;
    assign accept    = dmx.in_valid && dmx.in_ready;
`ifdef DEMUX_BCAST_EN
    // broadcast waits until every channel can take the beat
    assign dmx.in_ready = dmx.in_bcast ? &free : uni_ready;
    assign load         = !accept ? '0 : dmx.in_bcast ? '1 : uni_load;
    assign drop         = accept && !dmx.in_bcast && !in_range;
`else
    assign dmx.in_ready = uni_ready;
    assign load         = accept ? uni_load : '0;
    assign drop         = accept && !in_range;
`endif

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = load | (out_valid_q & ~dmx.out_ready);
        for (int k = 0; k < CHANNELS; k++)
            out_data_d[k*WIDTH +: WIDTH] = load[k] ? dmx.in_data : out_data_q[k*WIDTH +: WIDTH];
        err_cnt_d = (drop && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign dmx.out_data  = out_data_q;
    assign dmx.out_valid = out_valid_q;
    assign dmx.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_demux_stream_1_n.sv
// tb_demux_stream_1_n: directed scoreboard bench; 4-channel DUT plus a 3-channel DUT for the drop path.
module tb_demux_stream_1_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    typedef logic [7:0] q8_t[$];
    q8_t  exp_q[4];

    always #5 clk = ~clk;

    demux_stream_1_n_if #(.WIDTH(8), .CHANNELS(4)) a ();
    demux_stream_1_n_if #(.WIDTH(8), .CHANNELS(3)) b ();
    demux_stream_1_n #(.WIDTH(8), .CHANNELS(4)) dut_a (.clk(clk), .rst(rst), .dmx(a.slave));
    demux_stream_1_n #(.WIDTH(8), .CHANNELS(3)) dut_b (.clk(clk), .rst(rst), .dmx(b.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] sel, input logic bc, input logic exp_rdy);
        a.in_data  = d;
        a.in_sel   = sel;
        a.in_valid = 1'b1;
`ifdef DEMUX_BCAST_EN
        a.in_bcast = bc;
`endif
        #1;
        chk("in_ready", 32'(a.in_ready), 32'(exp_rdy));
        if (exp_rdy) begin
            if (bc) for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
            else exp_q[sel].push_back(d);
        end
        tick();
        a.in_valid = 1'b0;
`ifdef DEMUX_BCAST_EN
        a.in_bcast = 1'b0;
`endif
    endtask

    // scoreboard monitor: every completed output handshake must match the oldest queued beat
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (a.out_valid[k] && a.out_ready[k]) begin
                    if (exp_q[k].size() == 0) chk("unexpected_beat", 32'(k), 32'hffff);
                    else chk("out_data", 32'(a.out_data[k*8 +: 8]), 32'(exp_q[k].pop_front()));
                end
            end
        end
    end

    initial begin
        a.in_data = '0; a.in_sel = '0; a.in_valid = 1'b0; a.out_ready = '0;
        b.in_data = '0; b.in_sel = '0; b.in_valid = 1'b0; b.out_ready = '1;
`ifdef DEMUX_BCAST_EN
        a.in_bcast = 1'b0;
        b.in_bcast = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        // fill two channels, then reset while they hold data
        send(8'h10, 2'd0, 1'b0, 1'b1);
        send(8'h20, 2'd1, 1'b0, 1'b1);
        chk("held_before_reset", 32'(a.out_valid), 32'h3);
        rst = 1'b1;
        tick();
        chk("reset_valid", 32'(a.out_valid), 32'h0);
        chk("reset_data", a.out_data, 32'h0);
        chk("reset_err", 32'(a.err_cnt), 32'h0);
        chk("reset_ready", 32'(a.in_ready), 32'h1);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        a.out_ready = '1;
        // unicast
        send(8'hA5, 2'd2, 1'b0, 1'b1);
        chk("uni_valid", 32'(a.out_valid), 32'h4);
        chk("uni_data", 32'(a.out_data[23:16]), 32'hA5);
        tick();
        chk("uni_clear", 32'(a.out_valid), 32'h0);
        // back-pressure on channel 1, channel 0 unaffected
        a.out_ready = 4'b1101;
        send(8'h11, 2'd1, 1'b0, 1'b1);
        send(8'h22, 2'd1, 1'b0, 1'b0);
        send(8'h33, 2'd0, 1'b0, 1'b1);
        chk("bp_hold", 32'(a.out_data[15:8]), 32'h11);
        chk("bp_valid", 32'(a.out_valid[1]), 32'h1);
        a.out_ready = '1;
        send(8'h22, 2'd1, 1'b0, 1'b1);
        chk("bp_reload_valid", 32'(a.out_valid[1]), 32'h1);
        chk("bp_reload_data", 32'(a.out_data[15:8]), 32'h22);
        tick();
        // streaming to channel 3
        for (int i = 0; i < 16; i++) send(8'(i * 7 + 3), 2'd3, 1'b0, 1'b1);
        tick(); tick();
        chk("stream_idle", 32'(a.out_valid), 32'h0);
`ifdef DEMUX_BCAST_EN
        a.out_ready = 4'b1110;
        send(8'h77, 2'd0, 1'b0, 1'b1);
        send(8'h5A, 2'd2, 1'b1, 1'b0);
        a.out_ready = '1;
        send(8'h5A, 2'd2, 1'b1, 1'b1);
        chk("bcast_valid", 32'(a.out_valid), 32'hf);
        chk("bcast_data", a.out_data, 32'h5A5A5A5A);
        chk("bcast_err", 32'(a.err_cnt), 32'h0);
        tick();
`endif
        // out-of-range drops on the 3-channel instance
        for (int i = 0; i < 300; i++) begin
            b.in_data = 8'(i); b.in_sel = 2'd3; b.in_valid = 1'b1;
            #1;
            chk("oor_ready", 32'(b.in_ready), 32'h1);
            tick();
            chk("oor_err", 32'(b.err_cnt), (i + 1 < 255) ? 32'(i + 1) : 32'd255);
            chk("oor_valid", 32'(b.out_valid), 32'h0);
        end
        b.in_valid = 1'b0;
        b.in_sel = 2'd2; b.in_data = 8'h42; b.in_valid = 1'b1;
        tick();
        b.in_valid = 1'b0;
        chk("b_inrange_valid", 32'(b.out_valid), 32'h4);
        chk("b_inrange_data", 32'(b.out_data[23:16]), 32'h42);
        chk("b_err_hold", 32'(b.err_cnt), 32'd255);
        tick(); tick();
        for (int k = 0; k < 4; k++) chk("scoreboard_empty", 32'(exp_q[k].size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
